// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and helpers for the memory-access stage.
//   - mem_size_e  : access size encoding (byte/half/word/double)
//   - mem_state_e : access FSM state encoding
//   - size_mask() : byte-enable pattern for a size, before lane shifting
//   - is_misaligned() : natural-alignment test for a size and byte offset
package mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'b00,
        MEM_SIZE_H = 2'b01,
        MEM_SIZE_W = 2'b10,
        MEM_SIZE_D = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'b00,
        MEM_ST_WAIT = 2'b01,
        MEM_ST_DONE = 2'b10
    } mem_state_e;

    function automatic logic [7:0] size_mask(input mem_size_e size);
        logic [7:0] m;
        case (size)
            MEM_SIZE_B: m = 8'h01;
            MEM_SIZE_H: m = 8'h03;
            MEM_SIZE_W: m = 8'h0F;
            default:    m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] off);
        logic mis;
        case (size)
            MEM_SIZE_B: mis = 1'b0;
            MEM_SIZE_H: mis = off[0];
            MEM_SIZE_W: mis = |off[1:0];
            default:    mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_load_fmt.sv
// mem_access_load_fmt: combinational load formatter. Moves the addressed
// bytes of an aligned 64-bit read word down to bit 0, truncates to the
// access size and sign- or zero-extends. Shared with the cache read path.
//   rdata_i    : aligned read data from memory
//   offset_i   : byte offset of the access within the 8-byte word
//   size_i     : access size
//   unsigned_i : zero-extend instead of sign-extend (ignored for double)
//   data_o     : formatted writeback value
module mem_access_load_fmt
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [2:0]        offset_i,
    input  mem_size_e         size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = shifted;
        case (size_i)
            MEM_SIZE_B: data_o = {{(DATA_W-8){shifted[7]  & ~unsigned_i}}, shifted[7:0]};
            MEM_SIZE_H: data_o = {{(DATA_W-16){shifted[15] & ~unsigned_i}}, shifted[15:0]};
            MEM_SIZE_W: data_o = {{(DATA_W-32){shifted[31] & ~unsigned_i}}, shifted[31:0]};
            default:    data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: pipeline memory-access stage behind EX.
// Issues one load/store per memory instruction on a req/ack port, stalls
// the front of the pipe while the access is outstanding and presents the
// formatted result for one DONE cycle. Non-memory instructions pass
// straight through combinationally.
//   clk, rst               : clock, synchronous active-high reset
//   mem_access_*_i         : EX/MEM latch contents
//   dmem_*                 : data-memory request/response port
//   mem_access_stall_o     : hold IF/ID/EX and the EX/MEM latch
//   mem_access_done_o      : memory result valid this cycle
//   mem_access_misalign_o  : misaligned access detected (no request issued)
//   mem_access_rd_data_o   : value to MEM/WB
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_access_valid_i,
    input  logic              mem_access_mem_read_i,
    input  logic              mem_access_mem_write_i,
    input  logic [1:0]        mem_access_mem_size_i,
    input  logic              mem_access_mem_unsigned_i,
    input  logic [ADDR_W-1:0] mem_access_addr_i,
    input  logic [DATA_W-1:0] mem_access_store_data_i,
    input  logic [DATA_W-1:0] mem_access_rd_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic [7:0]        dmem_wmask_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              mem_access_stall_o,
    output logic              mem_access_done_o,
    output logic              mem_access_misalign_o,
    output logic [DATA_W-1:0] mem_access_rd_data_o
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_size_e         size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [DATA_W-1:0] result_q, result_d;

    mem_size_e         size_in;
    logic              is_mem;
    logic              misalign;
    logic              issue;
    logic [DATA_W-1:0] load_val;

    assign size_in  = mem_size_e'(mem_access_mem_size_i);
    assign is_mem   = mem_access_valid_i & (mem_access_mem_read_i | mem_access_mem_write_i);
    assign misalign = is_mem & is_misaligned(size_in, mem_access_addr_i[2:0]);

    mem_access_load_fmt #(
        .DATA_W (DATA_W)
    ) u_load_fmt (
        .rdata_i    (dmem_rdata_i),
        .offset_i   (addr_q[2:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_val)
    );

    always_comb begin
        state_d               = state_q;
        issue                 = 1'b0;
        dmem_req_o            = 1'b0;
        mem_access_stall_o    = 1'b0;
        mem_access_done_o     = 1'b0;
        mem_access_misalign_o = 1'b0;
        mem_access_rd_data_o  = '0;
        result_d              = result_q;
        case (state_q)
            MEM_ST_IDLE: begin
                if (misalign) begin
                    mem_access_misalign_o = 1'b1;
                end else if (is_mem) begin
                    mem_access_stall_o = 1'b1;
                    issue              = 1'b1;
                    state_d            = MEM_ST_WAIT;
                end else begin
                    mem_access_rd_data_o = mem_access_rd_data_i;
                end
            end
            MEM_ST_WAIT: begin
                dmem_req_o         = 1'b1;
                mem_access_stall_o = 1'b1;
                if (dmem_ack_i) begin
                    // Stores still retire a writeback value: the EX result,
                    // which the stalled EX/MEM latch is still holding.
                    result_d = we_q ? mem_access_rd_data_i : load_val;
                    state_d  = MEM_ST_DONE;
                end
            end
            MEM_ST_DONE: begin
                mem_access_done_o    = 1'b1;
                mem_access_rd_data_o = result_q;
                state_d              = MEM_ST_IDLE;
            end
            default: state_d = MEM_ST_IDLE;
        endcase
    end

    // Request registers are loaded only on issue so the port stays stable
    // for the whole WAIT period regardless of what upstream does.
    always_comb begin
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        if (issue) begin
            addr_d     = mem_access_addr_i;
            size_d     = size_in;
            unsigned_d = mem_access_mem_unsigned_i;
            // read+write together is treated as a write
            we_d       = mem_access_mem_write_i;
            wdata_d    = mem_access_store_data_i << {mem_access_addr_i[2:0], 3'b000};
            wmask_d    = size_mask(size_in) << mem_access_addr_i[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MEM_ST_IDLE;
            addr_q     <= '0;
            size_q     <= MEM_SIZE_B;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            result_q   <= result_d;
        end
    end

    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
    assign dmem_wdata_o = wdata_q;
    assign dmem_wmask_o = wmask_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, mrd, mwr, muns;
    logic [1:0]  msize;
    logic [63:0] maddr, msdata, mrdd;
    logic        req, we, ack;
    logic [63:0] daddr, wdata, rdata;
    logic [7:0]  wmask;
    logic        stall, done, mis;
    logic [63:0] rdo;

    int checks = 0;
    int errors = 0;

    typedef struct { bit mis; logic [63:0] val; } res_t;
    typedef struct { bit we; logic [63:0] addr; int cycles; } req_t;
    res_t sb[$];
    req_t rq[$];

    // Two byte memories: the reference model (updated from instruction
    // semantics) and the memory seen through the DUT port (updated only
    // from the DUT's wdata/wmask). Loads read the latter, expectations
    // come from the former.
    logic [7:0] model[128];
    logic [7:0] dram[128];

    mem_access dut (
        .clk                       (clk),
        .rst                       (rst),
        .mem_access_valid_i        (valid),
        .mem_access_mem_read_i     (mrd),
        .mem_access_mem_write_i    (mwr),
        .mem_access_mem_size_i     (msize),
        .mem_access_mem_unsigned_i (muns),
        .mem_access_addr_i         (maddr),
        .mem_access_store_data_i   (msdata),
        .mem_access_rd_data_i      (mrdd),
        .dmem_req_o                (req),
        .dmem_we_o                 (we),
        .dmem_addr_o               (daddr),
        .dmem_wdata_o              (wdata),
        .dmem_wmask_o              (wmask),
        .dmem_ack_i                (ack),
        .dmem_rdata_i              (rdata),
        .mem_access_stall_o        (stall),
        .mem_access_done_o         (done),
        .mem_access_misalign_o     (mis),
        .mem_access_rd_data_o      (rdo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 0; mrd = 0; mwr = 0; msize = 0; muns = 0;
        maddr = 0; msdata = 0; mrdd = 0;
    endtask

    function automatic logic [63:0] model_load(input int off, input int nb, input bit uns);
        logic [63:0] v;
        v = 0;
        for (int i = 0; i < nb; i++) v |= 64'(model[off+i]) << (8*i);
        if (!uns && nb < 8 && model[off+nb-1][7])
            for (int i = nb; i < 8; i++) v |= 64'hFF << (8*i);
        return v;
    endfunction

    task automatic set_word(input int off, input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            model[off+i] = v[8*i +: 8];
            dram[off+i]  = v[8*i +: 8];
        end
    endtask

    task automatic alu(input logic [63:0] v, input bit vld);
        valid = vld; mrd = 0; mwr = 0; mrdd = v;
        maddr = {$urandom, $urandom}; msize = 2'($urandom_range(0, 3));
        @(negedge clk);
        chk("pass_rd_data", rdo, v);
        chk("pass_stall", stall, 0);
        chk("pass_req", req, 0);
        $display("ALU valid=%0d rd_data=%h", vld, v);
        cyc();
    endtask

    task automatic mem_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input int off, input logic [63:0] sdata, input int lat, input bit dir_sh);
        int nb;
        int aoff;
        logic [63:0] rdv, exp_v, a;
        res_t r;
        req_t q;
        nb = 1 << sz;
        aoff = off & ~7;
        rdv = {$urandom, $urandom};
        a = BASE + 64'(off);
        valid = 1; mrd = rd; mwr = wr; msize = sz; muns = uns;
        maddr = a; msdata = sdata; mrdd = rdv;
        if (off % nb != 0) begin
            r.mis = 1; r.val = 0;
            sb.push_back(r);
            @(negedge clk);
            chk("mis_stall", stall, 0);
            chk("mis_req", req, 0);
            $display("MISALIGN size=%0d addr=%h", nb, a);
            cyc();
            return;
        end
        if (wr) begin
            exp_v = rdv;
            for (int i = 0; i < nb; i++) model[off+i] = sdata[8*i +: 8];
        end else begin
            exp_v = model_load(off, nb, uns);
        end
        r.mis = 0; r.val = exp_v;
        sb.push_back(r);
        q.we = wr; q.addr = a & ~64'h7; q.cycles = lat + 1;
        rq.push_back(q);
        @(negedge clk);
        chk("issue_stall", stall, 1);
        cyc();
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("wait_stall", stall, 1);
            cyc();
        end
        @(negedge clk);
        if (dir_sh) begin
            chk("sh_addr", daddr, 64'h8000_0000);
            chk("sh_wmask", wmask, 8'hC0);
            chk("sh_wdata_hi", wdata[63:48], 16'hABCD);
            chk("sh_we", we, 1);
        end
        chk("req_at_ack", req, 1);
        for (int j = 0; j < 8; j++) rdata[8*j +: 8] = dram[aoff+j];
        if (we)
            for (int j = 0; j < 8; j++)
                if (wmask[j]) dram[aoff+j] = wdata[8*j +: 8];
        ack = 1;
        cyc();
        ack = 0;
        rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("done_pulse", done, 1);
        $display("%s size=%0d uns=%0d addr=%h lat=%0d expect=%h",
                 wr ? "STORE" : "LOAD", nb, uns, a, lat + 1, exp_v);
        cyc();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result or a
    // new request, and measures how long each request stays up.
    initial begin
        bit in_req;
        int run;
        req_t cur;
        res_t r;
        in_req = 0; run = 0;
        cur.we = 0; cur.addr = 0; cur.cycles = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_req = 0; run = 0;
            end else begin
                if (req) begin
                    if (!in_req) begin
                        if (rq.size() == 0) begin
                            chk("unexpected_req", 1, 0);
                        end else begin
                            cur = rq.pop_front();
                            chk("req_we", we, cur.we);
                            chk("req_addr", daddr, cur.addr);
                        end
                        in_req = 1; run = 1;
                    end else begin
                        run++;
                    end
                end else if (in_req) begin
                    chk("req_cycles", 64'(run), 64'(cur.cycles));
                    in_req = 0;
                end
                if (done || mis) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        r = sb.pop_front();
                        chk("result_kind_mis", mis, r.mis);
                        chk("result_done", done, !r.mis);
                        chk("result_data", rdo, r.val);
                        chk("result_stall", stall, 0);
                    end
                end
            end
        end
    end

    initial begin
        int k, off, nb;
        logic [1:0] sz;
        bit rd, wr;
        rst = 1; ack = 0; rdata = 0;
        idle_inputs();
        for (int i = 0; i < 128; i++) begin
            model[i] = 8'($urandom);
            dram[i]  = model[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", req, 0);
        chk("reset_stall", stall, 0);
        chk("reset_done", done, 0);
        chk("reset_mis", mis, 0);
        chk("reset_rd_data", rdo, 0);
        cyc();
        rst = 0;

        // LD, ack on the third WAIT cycle
        set_word(16, 64'h1122_3344_5566_7788);
        mem_op(1, 0, 2'b11, 0, 16, 64'h0, 2, 0);
        // ADD directly after the LD's DONE cycle
        alu(64'h5, 1);
        // LB / LBU at 0x13
        set_word(16, 64'h0000_0000_8000_0000);
        mem_op(1, 0, 2'b00, 0, 19, 64'h0, 0, 0);
        mem_op(1, 0, 2'b00, 1, 19, 64'h0, 1, 0);
        // SH at 0x06
        mem_op(0, 1, 2'b01, 0, 6, 64'hABCD, 0, 1);
        // LW at 0x02: misaligned
        mem_op(1, 0, 2'b10, 0, 2, 64'h0, 0, 0);

        // reset during WAIT with a stray ack afterwards
        valid = 1; mrd = 1; mwr = 0; msize = 2'b11; muns = 0;
        maddr = BASE + 64'h20; mrdd = 0;
        rq.push_back('{0, BASE + 64'h20, 0});
        @(negedge clk);
        cyc();
        @(negedge clk);
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        idle_inputs();
        @(negedge clk);
        chk("rst_req_drop", req, 0);
        chk("rst_stall_drop", stall, 0);
        cyc();
        ack = 1; rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("stray_ack_req", req, 0);
        cyc();
        ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_ack_done", done, 0);
            chk("stray_ack_stall", stall, 0);
            cyc();
        end
        $display("RESET_IN_WAIT addr=%h", BASE + 64'h20);

        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 7);
            if (k < 2) begin
                alu({$urandom, $urandom}, 1'($urandom_range(0, 1)));
            end else begin
                sz = 2'($urandom_range(0, 3));
                nb = 1 << sz;
                off = $urandom_range(0, 127);
                if ($urandom_range(0, 9) < 8) off = off & ~(nb - 1);
                k = $urandom_range(0, 9);
                rd = (k < 5) || (k == 9);
                wr = (k >= 5);
                mem_op(rd, wr, sz, 1'($urandom_range(0, 1)), off,
                       {$urandom, $urandom}, $urandom_range(0, 3), 0);
            end
        end

        idle_inputs();
        repeat (3) cyc();
        chk("scoreboard_drained", 64'(sb.size()), 0);
        chk("requests_drained", 64'(rq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-access stage directly downstream of the execute stage. Consumes the EX/MEM latch (effective address from the EX result, forwarded rs2 store data, memory-control bits). Issues one load/store per instruction on a req/ack data-memory port, stalls the pipeline until the access completes, then presents the formatted writeback value to the MEM/WB latch. Non-memory instructions pass through with zero added latency.

Parameters:
ADDR_W, 64, data-memory address width
DATA_W, 64, register/data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_access_valid_i  in  1  EX/MEM holds a valid instruction
mem_access_mem_read_i  in  1  load
mem_access_mem_write_i  in  1  store
mem_access_mem_size_i  in  2  00 byte, 01 half, 10 word, 11 double
mem_access_mem_unsigned_i  in  1  zero-extend the load (LBU/LHU/LWU)
mem_access_addr_i  in  64  effective address (EX result)
mem_access_store_data_i  in  64  forwarded rs2 value
mem_access_rd_data_i  in  64  EX result for non-memory instructions
dmem_req_o  out  1  request valid
dmem_we_o  out  1  1 = write
dmem_addr_o  out  64  8-byte-aligned address
dmem_wdata_o  out  64  lane-shifted store data
dmem_wmask_o  out  8  byte enables
dmem_ack_i  in  1  access complete; rdata valid this cycle
dmem_rdata_i  in  64  aligned 64-bit read data
mem_access_stall_o  out  1  hold IF/ID/EX and the EX/MEM latch
mem_access_done_o  out  1  memory access result valid this cycle
mem_access_misalign_o  out  1  misaligned access detected
mem_access_rd_data_o  out  64  value to MEM/WB

Behaviour:
- Single clock, synchronous active-high reset. Reset state: IDLE; all registered outputs 0; dmem_req_o=0, stall_o=0, done_o=0.
- mem = valid & (read|write). misalign = mem & addr not aligned to size (half: addr[0]; word: addr[1:0]; double: addr[2:0]).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - mem & ~misalign: stall_o=1. Capture addr, size, unsigned, we, wdata, wmask into request registers. Next state WAIT.
  - misalign: misalign_o=1, stall_o=0, rd_data_o=0. No request issued. Stay in IDLE.
  - Otherwise: rd_data_o = rd_data_i combinationally, stall_o=0.
- WAIT:
  - dmem_req_o=1 and stall_o=1.
  - addr/we/wdata/wmask driven from the registers and held stable until ack.
  - On dmem_ack_i: register the formatted load value (loads) or rd_data_i (stores). Next state DONE.
- DONE: stall_o=0, done_o=1, rd_data_o = the registered value. Next state IDLE unconditionally. The upstream stage advances at the end of this cycle, so the instruction is not reissued.
- Minimum memory latency is 2 cycles beyond the issue cycle (ack on the first WAIT cycle).
- dmem_ack_i is ignored outside WAIT.
- Store lanes:
  - wmask = (size mask 0x01/0x03/0x0F/0xFF) << addr[2:0].
  - wdata = store_data << (addr[2:0]*8).
  - dmem_addr_o = {addr[63:3], 3'b000}.
- Load formatting: shift rdata right by addr[2:0]*8, then truncate to the access size. Sign-extend unless unsigned. The unsigned bit is ignored for double.
- rst asserted in WAIT or DONE: state goes to IDLE and req/stall drop on the next cycle. A later stray ack is ignored.
- Simultaneous read & write is illegal upstream; treat it as a write.

Decomposition:
- defines.v gets `MEM_SIZE_BUS`, `MEM_SIZE_B/H/W/D` and the FSM state encodings `MEM_ST_IDLE/WAIT/DONE`.
- One combinational sub-module, mem_load_fmt, holds the lane extraction and sign/zero extension. It is reused by the later cache path.
- Store lane generation stays inline.

Test Plan:
- LD at 0x80000010, ack 3 cycles after entering WAIT, rdata 0x1122334455667788 -> req high 3 cycles; stall high from the issue cycle through ack; DONE cycle gives rd_data_o=0x1122334455667788, done_o=1.
- LB at 0x80000013, rdata 0x0000000080000000 -> rd_data_o=0xFFFFFFFFFFFFFF80. Same access as LBU -> 0x0000000000000080.
- SH at 0x80000006, store_data 0xABCD -> dmem_addr_o=0x80000000, wmask=0xC0, wdata[63:48]=0xABCD, we=1.
- LW at 0x80000002 -> misalign_o=1, no req, stall_o=0, rd_data_o=0.
- rst pulsed during WAIT, ack asserted 2 cycles later -> req/stall 0 the cycle after rst; ack ignored; done_o never asserted.
- ADD result 0x5 directly after a LD's DONE cycle -> rd_data_o=0x5 in the same cycle, stall_o=0, no req.
